// File: rtl/f_adder_back_pkg.sv
// Shared FPU constants: rounding-mode encodings, the MIPS legacy default NaN and helpers that
// derive exponent bias / all-ones exponent from the exponent width.
package f_adder_back_pkg;

   localparam logic [1:0] RM_RN = 2'd0;
   localparam logic [1:0] RM_RZ = 2'd1;
   localparam logic [1:0] RM_RP = 2'd2;
   localparam logic [1:0] RM_RM = 2'd3;

   // MIPS legacy quiet NaN: quiet bit clear, remaining fraction bits set.
   localparam logic [63:0] DEFAULT_NAN_D = 64'h7FF7_FFFF_FFFF_FFFF;

   function automatic int unsigned exp_bias(input int unsigned ew);
      return (32'd1 << (ew - 1)) - 32'd1;
   endfunction

   function automatic int unsigned exp_max(input int unsigned ew);
      return (32'd1 << ew) - 32'd1;
   endfunction

endpackage

// File: rtl/f_lzc108.sv
// Combinational leading-zero counter. An all-zero input returns width (truncated to the output
// width); callers that care about zero detect it separately.
module f_lzc108 #(
   parameter int unsigned width     = 108,
   parameter int unsigned cnt_width = $clog2(width)
) (
   input  logic [width-1:0]     i_data,
   output logic [cnt_width-1:0] o_cnt
);

   always_comb begin
      o_cnt = cnt_width'(width);
      for (int i = 0; i < width; i++) begin
         if (i_data[i]) o_cnt = cnt_width'(width - 1 - 32'(i));
      end
   end

endmodule

// File: rtl/f_adder_back.sv
// FP adder back end: normalize, round and pack a signed long fraction into an IEEE-754 result
// with MIPS FCSR cause flags. Three registered stages share the front end's stall and flush.
module f_adder_back
   import f_adder_back_pkg::*;
#(
   parameter int unsigned info_width = 1,
   parameter int unsigned exp_width  = 11,
   parameter int unsigned frac_width = 52
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           a_wait,
   input  logic                           flush,
   output logic                           busy,
   input  logic [1:0]                     rm,
   input  logic [exp_width+1:0]           in_exp,
   input  logic [2*frac_width+3:0]        in_frac,
   input  logic                           in_inf,
   input  logic                           in_invalid,
   input  logic [info_width-1:0]          info_in,
   output logic [exp_width+frac_width:0]  result,
   output logic [info_width-1:0]          info_out,
   output logic                           f_overflow,
   output logic                           f_underflow,
   output logic                           f_inexact,
   output logic                           f_invalid
);

   localparam int unsigned FL  = 2 * frac_width + 4;
   localparam int unsigned CW  = $clog2(FL);
   localparam int unsigned EW3 = exp_width + 3;
   localparam int unsigned SW  = frac_width + 1;
   localparam int unsigned SW1 = SW + 1;
   localparam int unsigned RW  = exp_width + frac_width + 1;
   localparam int unsigned SAT = frac_width + 4;
   localparam logic [EW3-1:0] EMAX    = EW3'(exp_max(exp_width));
   localparam logic [RW-1:0]  NAN_GEN = {1'b0, {exp_width{1'b1}}, 1'b0, {(frac_width-1){1'b1}}};
   localparam logic [RW-1:0]  NAN     = (RW == 64) ? RW'(DEFAULT_NAN_D) : NAN_GEN;

   assign busy = a_wait;

   // ---------------- Stage 1: sign / magnitude / leading-zero count ----------------
   logic                  w1_sign;
   logic [FL-1:0]         w1_mag;
   logic [CW-1:0]         w1_lz;
   logic [info_width-1:0] w1_info;

   assign w1_sign = in_frac[FL-1];
   assign w1_mag  = w1_sign ? -in_frac : in_frac;

   always_comb begin
      w1_info    = info_in;
      w1_info[0] = info_in[0] & ~flush;
   end

   f_lzc108 #(
      .width (FL)
   ) u_lzc (
      .i_data (w1_mag),
      .o_cnt  (w1_lz)
   );

   logic                  r1_sign, r1_zero, r1_inf, r1_invalid;
   logic [FL-1:0]         r1_mag;
   logic [CW-1:0]         r1_lz;
   logic [exp_width+1:0]  r1_exp;
   logic [1:0]            r1_rm;
   logic [info_width-1:0] r1_info;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1_sign    <= 1'b0;
         r1_zero    <= 1'b0;
         r1_inf     <= 1'b0;
         r1_invalid <= 1'b0;
         r1_mag     <= '0;
         r1_lz      <= '0;
         r1_exp     <= '0;
         r1_rm      <= '0;
         r1_info    <= '0;
      end else if (!a_wait) begin
         r1_sign    <= w1_sign;
         r1_zero    <= (w1_mag == '0);
         r1_inf     <= in_inf;
         r1_invalid <= in_invalid;
         r1_mag     <= w1_mag;
         r1_lz      <= w1_lz;
         r1_exp     <= in_exp;
         r1_rm      <= rm;
         r1_info    <= w1_info;
      end else if (flush) begin
         r1_info[0] <= 1'b0;
      end
   end

   // ---------------- Stage 2: normalize, denormalize tiny results ----------------
   logic [EW3-1:0] w2_e, w2_sh_raw;
   logic           w2_tiny, w2_lost;
   logic [CW-1:0]  w2_sh;
   logic [FL-1:0]  w2_norm, w2_al;

   always_comb begin
      w2_e      = EW3'(r1_exp) + EW3'(2) - EW3'(r1_lz);
      w2_tiny   = w2_e[EW3-1] | (w2_e == '0);
      w2_sh_raw = EW3'(1) - w2_e;
      w2_sh     = '0;
      if (w2_tiny) w2_sh = (w2_sh_raw > EW3'(SAT)) ? CW'(SAT) : CW'(w2_sh_raw);
      w2_norm   = r1_mag << r1_lz;
      w2_al     = w2_norm >> w2_sh;
      w2_lost   = |(w2_norm & ~({FL{1'b1}} << w2_sh));
   end

   logic                  r2_sign, r2_zero, r2_inf, r2_invalid, r2_tiny, r2_guard, r2_sticky;
   logic [SW-1:0]         r2_sig;
   logic [EW3-1:0]        r2_exp;
   logic [1:0]            r2_rm;
   logic [info_width-1:0] r2_info;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r2_sign    <= 1'b0;
         r2_zero    <= 1'b0;
         r2_inf     <= 1'b0;
         r2_invalid <= 1'b0;
         r2_tiny    <= 1'b0;
         r2_guard   <= 1'b0;
         r2_sticky  <= 1'b0;
         r2_sig     <= '0;
         r2_exp     <= '0;
         r2_rm      <= '0;
         r2_info    <= '0;
      end else if (!a_wait) begin
         r2_sign    <= r1_sign;
         r2_zero    <= r1_zero;
         r2_inf     <= r1_inf;
         r2_invalid <= r1_invalid;
         r2_tiny    <= w2_tiny;
         r2_guard   <= w2_al[FL-SW-1];
         r2_sticky  <= (|w2_al[FL-SW-2:0]) | w2_lost;
         r2_sig     <= w2_al[FL-1 -: SW];
         r2_exp     <= w2_tiny ? '0 : w2_e;
         r2_rm      <= r1_rm;
         r2_info    <= r1_info;
         r2_info[0] <= r1_info[0] & ~flush;
      end else if (flush) begin
         r2_info[0] <= 1'b0;
      end
   end

   // ---------------- Stage 3: round and pack ----------------
   logic                  w3_inexact, w3_inc, w3_carry, w3_ovf, w3_ovf_inf;
   logic                  w3_f_ovf, w3_f_unf, w3_f_inx, w3_f_inv;
   logic [SW:0]           w3_sum;
   logic [frac_width-1:0] w3_frac;
   logic [EW3-1:0]        w3_exp;
   logic [RW-1:0]         w3_res, w3_inf, w3_max;

   always_comb begin
      w3_inexact = r2_guard | r2_sticky;
      w3_inc     = 1'b0;
      case (r2_rm)
         RM_RN: w3_inc = r2_guard & (r2_sticky | r2_sig[0]);
         RM_RZ: w3_inc = 1'b0;
         RM_RP: w3_inc = ~r2_sign & w3_inexact;
         RM_RM: w3_inc = r2_sign & w3_inexact;
      endcase
      w3_sum   = {1'b0, r2_sig} + SW1'(w3_inc);
      w3_carry = w3_sum[SW];
      w3_frac  = w3_carry ? w3_sum[frac_width:1] : w3_sum[frac_width-1:0];
      // A subnormal that rounds into the hidden bit becomes the smallest normal.
      if (w3_carry)                           w3_exp = r2_exp + EW3'(1);
      else if (r2_tiny && w3_sum[frac_width]) w3_exp = EW3'(1);
      else                                    w3_exp = r2_exp;
      w3_ovf     = (w3_exp >= EMAX);
      w3_ovf_inf = (r2_rm == RM_RN) | ((r2_rm == RM_RP) & ~r2_sign) | ((r2_rm == RM_RM) & r2_sign);
      w3_inf     = {r2_sign, {exp_width{1'b1}}, {frac_width{1'b0}}};
      w3_max     = {r2_sign, {(exp_width-1){1'b1}}, 1'b0, {frac_width{1'b1}}};

      w3_res   = {r2_sign, w3_exp[exp_width-1:0], w3_frac};
      w3_f_ovf = 1'b0;
      w3_f_unf = r2_tiny & w3_inexact;
      w3_f_inx = w3_inexact;
      w3_f_inv = 1'b0;
      if (r2_invalid) begin
         w3_res   = NAN;
         w3_f_unf = 1'b0;
         w3_f_inx = 1'b0;
         w3_f_inv = 1'b1;
      end else if (r2_inf) begin
         w3_res   = w3_inf;
         w3_f_unf = 1'b0;
         w3_f_inx = 1'b0;
      end else if (r2_zero) begin
         w3_res   = {(r2_rm == RM_RM), {(RW-1){1'b0}}};
         w3_f_unf = 1'b0;
         w3_f_inx = 1'b0;
      end else if (w3_ovf) begin
         w3_res   = w3_ovf_inf ? w3_inf : w3_max;
         w3_f_ovf = 1'b1;
         w3_f_unf = 1'b0;
         w3_f_inx = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result      <= '0;
         info_out    <= '0;
         f_overflow  <= 1'b0;
         f_underflow <= 1'b0;
         f_inexact   <= 1'b0;
         f_invalid   <= 1'b0;
      end else if (!a_wait) begin
         result      <= w3_res;
         info_out    <= r2_info;
         info_out[0] <= r2_info[0] & ~flush;
         f_overflow  <= w3_f_ovf;
         f_underflow <= w3_f_unf;
         f_inexact   <= w3_f_inx;
         f_invalid   <= w3_f_inv;
      end else if (flush) begin
         info_out[0] <= 1'b0;
      end
   end

endmodule

// File: doc/f_adder_back.md
# f_adder_back

Floating-point adder back end: the normalize / round / pack half of the FP add datapath. It accepts the unnormalized exponent and long signed fraction produced by the adder front end. It emits an IEEE-754 packed result with MIPS FCSR exception flags. The block is a 3-stage pipeline sharing the front end's stall (`a_wait`) and flush conventions, and sits between the front end and the FPU writeback mux.

## Interface
Parameters:
- `info_width`, 1: width of the side-band info bus; bit 0 is the valid bit.
- `exp_width`, 11: packed exponent width (11 = double).
- `frac_width`, 52: packed fraction width.

Ports:
- `clk`  in  1  clock. One clock; all state on `posedge clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `a_wait`  in  1  stall. While high, all pipeline registers hold.
- `flush`  in  1  clears `info[0]` in every stage; all other fields are unaffected.
- `busy`  out  1  equal to `a_wait`.
- `rm`  in  2  rounding mode: 0 RN (nearest-even), 1 RZ, 2 RP (+inf), 3 RM (-inf). Sampled with the input operand.
- `in_exp`  in  `exp_width+2`  unsigned biased exponent. Bias is 2^(`exp_width`-1)-1.
- `in_frac`  in  `2*frac_width+4`  two's-complement fraction in fixed point: 3 integer bits [107:105], 105 fraction bits.
- `in_inf`  in  1  operand was ±infinity (non-invalid case).
- `in_invalid`  in  1  invalid operation.
- `info_in`  in  `info_width`  side-band data, carried unchanged.
- `result`  out  `exp_width+frac_width+1`  packed result.
- `info_out`  out  `info_width`  side-band data aligned with `result`.
- `f_overflow`, `f_underflow`, `f_inexact`, `f_invalid`  out  1 each  FCSR cause bits.

## Operation
Value represented by the inputs: (`in_frac` / 2^105) × 2^(`in_exp` − bias).

Stage 1 (abs / LZC):
- sign = `in_frac[MSB]`; mag = |`in_frac`|. mag is at most 2^107 and fits in 108 bits unsigned.
- p = index of the leading one of mag.
- zero flag = (mag == 0).

Stage 2 (normalize):
- e = `in_exp` + p − 105, computed signed at `exp_width+3` bits.
- Left-align mag so the leading one is at bit 107.
- If e ≤ 0 (subnormal): right-shift by 1−e, saturating at 56; OR all shifted-out bits into sticky; set e = 0.
- Keep a 53-bit significand, a guard bit, and sticky (OR of all lower bits).

Stage 3 (round / pack):
- Increment decision:
  - RN: guard & (sticky | lsb).
  - RZ: never.
  - RP: ~sign & (guard | sticky).
  - RM: sign & (guard | sticky).
- inexact = guard | sticky.
- Rounding carry-out renormalizes: e+1. A subnormal that rounds into the hidden bit becomes e = 1.
- If e ≥ 2^`exp_width`−1 (overflow): set `f_overflow` and `f_inexact`.
  - Result is ±inf, except RZ, RP-when-negative and RM-when-positive, which return ±max finite (`0x7FEF_FFFF_FFFF_FFFF` for double).
- `f_underflow` = tiny (pre-round e ≤ 0) & inexact.
- Exact zero: +0, or −0 when rm = RM. No flags.

Priority at pack: `in_invalid` > `in_inf` > zero > overflow > normal/subnormal.
- `in_invalid`: result = DEFAULT_NAN (MIPS legacy qNaN, `0x7FF7_FFFF_FFFF_FFFF`), `f_invalid` = 1, all other flags 0.
- `in_inf`: result = ±inf using the fraction sign. No flags.

Flags and `result` are meaningful only while `info_out[0]` = 1. Downstream gates them with that bit.

## Timing
- Latency: 3 un-stalled cycles from input sample to `result`/`info_out`.
- Throughput: 1 operation per cycle.
- Reset: all pipeline registers and all outputs are 0 (`result` = 0, flags = 0, `info_out` = 0) asynchronously. Reset mid-operation drops all in-flight operations.
- `a_wait` high: no register changes. The exception is `flush`, which still clears `info[0]` in all 3 stages and in `info_out`.
- `flush` and `a_wait` together: flush wins for bit 0 only.
- A bubble (`info_in[0]` = 0) propagates normally. Its datapath contents are don't-care.

## Structure
- Shared FPU package holds:
  - `RM_RN`/`RM_RZ`/`RM_RP`/`RM_RM` encodings;
  - `DEFAULT_NAN_D`;
  - bias and max-exponent constants derived from `exp_width`.
- One sub-module: `f_lzc108`, a parameterized combinational leading-zero counter (width `2*frac_width+4`, output `$clog2` bits), instantiated in stage 1.

## Test plan
1. 3.0: `in_exp`=1023, `in_frac`=3<<105, rm=0 → `result`=`0x4008_0000_0000_0000`, no flags, exactly 3 cycles after input.
2. −1.0: `in_frac`=−(1<<105), `in_exp`=1023 → `0xBFF0_0000_0000_0000`.
3. Zero: `in_frac`=0 with rm=0 → `0x0000_0000_0000_0000`; with rm=3 → `0x8000_0000_0000_0000`; no flags.
4. Ties: `in_frac`=(1<<105)|(1<<52), rm=0 → `0x3FF0_0000_0000_0000`, `f_inexact`=1. Adding bit 1<<53 → `0x3FF0_0000_0000_0002`. Same input with rm=1 → `0x3FF0_0000_0000_0001`.
5. Overflow: `in_exp`=2046, `in_frac`=2<<105. rm=0 → `0x7FF0_0000_0000_0000` with `f_overflow`=`f_inexact`=1. rm=1 → `0x7FEF_FFFF_FFFF_FFFF`.
6. Control, using a back-to-back stream of 4 ops:
   - hold `a_wait` 2 cycles mid-stream: outputs stay frozen, no op is lost or duplicated;
   - pulse `flush`: all in-flight `info[0]` go to 0;
   - `in_invalid`=1 → `0x7FF7_FFFF_FFFF_FFFF`, `f_invalid`=1;
   - assert `reset` asynchronously mid-stream: all outputs are 0 before the next clock edge.
